// File: rtl/led_seq_pkg.sv
// Shared codes for the LED pattern sequencer: modes, FSM states,
// bounce direction and the pattern loaded when a run starts.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BLINK  = 2'd3
    } modeT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } stateT;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dirT;

    // Every initial pattern is either all-zero or a lone LSB, whatever the
    // LED width, so only the LSB needs to be stored per mode.
    localparam logic INIT_LSB_ROTATE = 1'b1;
    localparam logic INIT_LSB_BOUNCE = 1'b1;
    localparam logic INIT_LSB_COUNT  = 1'b0;
    localparam logic INIT_LSB_BLINK  = 1'b0;

    function automatic logic initLsb(input modeT m);
        logic lsb;
        unique case (m)
            MODE_ROTATE: lsb = INIT_LSB_ROTATE;
            MODE_BOUNCE: lsb = INIT_LSB_BOUNCE;
            MODE_COUNT:  lsb = INIT_LSB_COUNT;
            default:     lsb = INIT_LSB_BLINK;
        endcase
        return lsb;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..CLK_DIV-1 while enabled and flags the last
// count. oTICK is a same-cycle request; the parent registers it so that its
// own tick output lines up with the LED update.
module led_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iEN,
    input  logic iCLR,
    output logic oTICK
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    // Count only when enabled; a disabled prescaler keeps its value so a
    // paused run resumes mid-period. Clear wins over enable.
    always_ff @(posedge iCLK) begin
        if (iRST || iCLR) begin
            count <= '0;
        end else if (iEN) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign oTICK = iEN && (count == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: IDLE/RUN/PAUSE control, mode latch, bounce
// direction and the registered LED pattern, stepped by led_tick_gen.
// Control inputs are single-cycle strobes with no handshake: a strobe is
// acted on in the cycle it is high and otherwise ignored; iSTOP has priority
// over iSTART whenever both are high.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int CLK_DIV = 25_000_000,
    parameter int LED_W   = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic             iSTOP,
    input  logic [1:0]       iMODE,
    output logic [LED_W-1:0] oLED,
    output logic             oBUSY,
    output logic             oTICK,
    output logic [1:0]       oState
);

    stateT            state, stateNext;
    modeT             mode, modeNext;
    dirT              dir, dirNext;
    logic [LED_W-1:0] led, ledNext;
    logic             tick, tickNext;
    logic             stepReq;
    logic             tickEn;
    logic             tickClr;

    // A stop in RUN freezes the prescaler in the same cycle, which also
    // swallows a tick that would have landed on that edge.
    assign tickEn  = (state == ST_RUN) && !iSTOP;
    assign tickClr = (state == ST_PAUSE) && iSTOP;

    led_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) uTickGen (
        .iCLK (iCLK),
        .iRST (iRST),
        .iEN  (tickEn),
        .iCLR (tickClr),
        .oTICK(stepReq)
    );

    // Register every piece of state; all outputs come straight from these.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= ST_IDLE;
            mode  <= MODE_ROTATE;
            dir   <= DIR_LEFT;
            led   <= '0;
            tick  <= 1'b0;
        end else begin
            state <= stateNext;
            mode  <= modeNext;
            dir   <= dirNext;
            led   <= ledNext;
            tick  <= tickNext;
        end
    end

    // Next-state, mode latch, direction and pattern stepping.
    always_comb begin
        stateNext = state;
        modeNext  = mode;
        dirNext   = dir;
        ledNext   = led;
        tickNext  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (iSTART && !iSTOP) begin
                    stateNext = ST_RUN;
                    modeNext  = modeT'(iMODE);
                    dirNext   = DIR_LEFT;
                    ledNext   = {{(LED_W-1){1'b0}}, initLsb(modeT'(iMODE))};
                end
            end
            ST_RUN: begin
                if (iSTOP) begin
                    stateNext = ST_PAUSE;
                end else if (stepReq) begin
                    tickNext = 1'b1;
                    unique case (mode)
                        MODE_ROTATE: ledNext = {led[LED_W-2:0], led[LED_W-1]};
                        MODE_BOUNCE: begin
                            // Reverse at either end so the lit bit reflects
                            // instead of falling off the vector.
                            if (dir == DIR_LEFT) begin
                                if (led[LED_W-1]) begin
                                    dirNext = DIR_RIGHT;
                                    ledNext = led >> 1;
                                end else begin
                                    ledNext = led << 1;
                                end
                            end else begin
                                if (led[0]) begin
                                    dirNext = DIR_LEFT;
                                    ledNext = led << 1;
                                end else begin
                                    ledNext = led >> 1;
                                end
                            end
                        end
                        MODE_COUNT:  ledNext = led + {{(LED_W-1){1'b0}}, 1'b1};
                        default:     ledNext = ~led;
                    endcase
                end
            end
            ST_PAUSE: begin
                if (iSTOP) begin
                    stateNext = ST_IDLE;
                    ledNext   = '0;
                end else if (iSTART) begin
                    stateNext = ST_RUN;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                ledNext   = '0;
            end
        endcase
    end

    assign oLED   = led;
    assign oTICK  = tick;
    assign oBUSY  = (state != ST_IDLE);
    assign oState = state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (CLK_DIV=4, LED_W=8).
// The reference model tracks run state, prescaler phase and number of steps
// taken, and derives the expected LED value from the step number directly.
module tb_led_pattern_sequencer;
    import led_seq_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int LED_W   = 8;

    // Clock / reset block
    logic             iCLK = 1'b0;
    logic             iRST = 1'b1;
    logic             iSTART = 1'b0;
    logic             iSTOP = 1'b0;
    logic [1:0]       iMODE = 2'd0;
    logic [LED_W-1:0] oLED;
    logic             oBUSY;
    logic             oTICK;
    logic [1:0]       oState;

    always #5 iCLK = ~iCLK;

    led_pattern_sequencer #(
        .CLK_DIV(CLK_DIV),
        .LED_W  (LED_W)
    ) dut (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iSTART(iSTART),
        .iSTOP (iSTOP),
        .iMODE (iMODE),
        .oLED  (oLED),
        .oBUSY (oBUSY),
        .oTICK (oTICK),
        .oState(oState)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    stateT mSt   = ST_IDLE;
    int    mMode = 0;
    int    mK    = 0;
    int    mPh   = 0;
    logic  mTick = 1'b0;

    function automatic logic [LED_W-1:0] expPattern(input int md, input int k);
        int p;
        int idx;
        case (md)
            0: return LED_W'(1 << (k % LED_W));
            1: begin
                p   = k % (2 * (LED_W - 1));
                idx = (p <= LED_W - 1) ? p : 2 * (LED_W - 1) - p;
                return LED_W'(1 << idx);
            end
            2: return LED_W'(k % (1 << LED_W));
            default: return ((k % 2) == 1) ? {LED_W{1'b1}} : {LED_W{1'b0}};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic s, input logic p, input logic [1:0] m, input logic r);
        if (r) begin
            mSt = ST_IDLE; mMode = 0; mK = 0; mPh = 0; mTick = 1'b0;
        end else begin
            mTick = 1'b0;
            case (mSt)
                ST_IDLE: if (s && !p) begin
                    mSt = ST_RUN; mMode = int'(m); mK = 0; mPh = 0;
                end
                ST_RUN: begin
                    if (p) mSt = ST_PAUSE;
                    else if (mPh == CLK_DIV - 1) begin
                        mPh = 0; mK++; mTick = 1'b1;
                    end else mPh++;
                end
                ST_PAUSE: begin
                    if (p) begin mSt = ST_IDLE; mPh = 0; end
                    else if (s) mSt = ST_RUN;
                end
                default: mSt = ST_IDLE;
            endcase
        end
    endtask

    // Driver: apply one cycle of inputs, advance the model, compare outputs.
    task automatic cyc(input logic s, input logic p, input logic [1:0] m, input logic r);
        logic [LED_W-1:0] expLed;
        iSTART = s; iSTOP = p; iMODE = m; iRST = r;
        @(posedge iCLK);
        modelStep(s, p, m, r);
        #1;
        expLed = (mSt == ST_IDLE) ? '0 : expPattern(mMode, mK);
        check("led",   32'(oLED),   32'(expLed));
        check("busy",  32'(oBUSY),  32'(mSt != ST_IDLE));
        check("tick",  32'(oTICK),  32'(mTick));
        check("state", 32'(oState), 32'(mSt));
        iSTART = 1'b0; iSTOP = 1'b0; iRST = 1'b0;
    endtask

    task automatic idle(input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, m, 1'b0);
    endtask

    initial begin
        // Reset
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        // Rotate through a full wrap
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        idle(9 * CLK_DIV, 2'd0);
        // Reset held two cycles mid-run
        idle(2, 2'd0);
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1);
        check("reset_led", 32'(oLED), 32'h0);
        idle(3, 2'd0);
        // Bounce 16+ steps
        cyc(1'b1, 1'b0, 2'd1, 1'b0);
        idle(17 * CLK_DIV, 2'd1);
        check("bounce_onehot", 32'($countones(oLED)), 32'd1);
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b0);
        // Count with pause/resume
        cyc(1'b1, 1'b0, 2'd2, 1'b0);
        idle(3 * CLK_DIV, 2'd2);
        check("count_three", 32'(oLED), 32'h03);
        cyc(1'b0, 1'b1, 2'd2, 1'b0);
        idle(20, 2'd0);
        check("pause_hold", 32'(oLED), 32'h03);
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        idle(2 * CLK_DIV, 2'd3);
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        check("stop_idle_led", 32'(oLED), 32'h00);
        // Count wrap
        cyc(1'b1, 1'b0, 2'd2, 1'b0);
        idle(256 * CLK_DIV + 2, 2'd2);
        cyc(1'b0, 1'b1, 2'd2, 1'b0);
        cyc(1'b0, 1'b1, 2'd2, 1'b0);
        // Blink, with iMODE changing mid-run
        cyc(1'b1, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 4 * CLK_DIV; i++) cyc(1'b0, 1'b0, 2'(i), 1'b0);
        // Start+stop together in RUN -> pause
        cyc(1'b1, 1'b1, 2'd0, 1'b0);
        check("race_pause", 32'(oState), 32'(ST_PAUSE));
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        // Stop coincident with a tick: rotate, stop on the 4th cycle
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        idle(CLK_DIV - 1, 2'd0);
        cyc(1'b0, 1'b1, 2'd0, 1'b0);
        check("stop_tick_led", 32'(oLED), 32'h01);
        check("stop_tick_pulse", 32'(oTICK), 32'h0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
        check("resume_step", 32'(oLED), 32'h02);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
                2'($urandom_range(0, 3)), ($urandom_range(0, 399) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the directed sequence has no open-ended waits, this only
    // guards against a stuck simulation.
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
